frame_ram_arbiter: RTL and testbench
====================================

// Module: frame_ram_arbiter
// PURPOSE
//  Sole owner of the 8x8 bicolour frame RAM port. Shares the port among three requesters:
//   - the clear engine (system RST, produces rst_ok)
//   - the LED-matrix scan reader (one row per refresh slot)
//   - the light-pen writer (DRAW/WRITE/ERASE).
//  Pen writes are done as row read-modify-write. Sits between the st state machine / pen path and the single-port RAM.
// PARAMETERS
//  ROWS    8  rows in frame; also number of clear cycles
//  COLS    8  columns; row word = {green[COLS-1:0], red[COLS-1:0]}
//  ADDR_W  3  row address width, clog2(ROWS)
// PORTS
//  clk        in   1         system clock
//  rst_n      in   1         asynchronous active-low reset
//  clr_req    in   1         start full-frame clear (level or pulse, sampled in IDLE)
//  clr_busy   out  1         high while clearing
//  clr_done   out  1         1-cycle pulse after last clear write (drives rst_ok)
//  scan_req   in   1         scan read request, held until scan_ack
//  scan_row   in   ADDR_W    row to read
//  scan_ack   out  1         1-cycle pulse; scan_data valid in the same cycle
//  scan_data  out  2*COLS    row word read
//  pen_req    in   1         pen write request, held until pen_ack (already gated by state upstream)
//  pen_row    in   ADDR_W    pixel row
//  pen_col    in   ADDR_W    pixel column (bit index)
//  pen_op     in   2         00 erase both, 01 set red, 10 set green, 11 set both
//  pen_ack    out  1         1-cycle pulse, coincident with ram_we of the RMW
//  ram_addr   out  ADDR_W    RAM row address (registered)
//  ram_we     out  1         RAM write enable (registered)
//  ram_wdata  out  2*COLS    RAM write data (registered)
//  ram_rdata  in   2*COLS    RAM read data, synchronous: valid 1 cycle after ram_addr
// BEHAVIOUR
//  - Reset (async, rst_n=0): state IDLE; all outputs 0; any clear in progress is aborted and no clr_done is issued.
//  - FSM states: IDLE, CLR, SCAN_WAIT, SCAN_CAP, PEN_WAIT, PEN_WR.
//  - Grant rule: IDLE evaluates requests each edge. Priority is clr_req > scan_req > pen_req (see CONFIGURATION).
//  - A requester whose ack is high in the current cycle is ignored, so a held request is not double-served.
//  - CLR:
//     - Entered at edge k. ram_we=1, ram_wdata=0, ram_addr = 0..ROWS-1 over ROWS consecutive cycles; clr_busy=1 throughout.
//     - clr_done pulses in the cycle after the last write; FSM returns to IDLE.
//     - clr_req is ignored while in CLR. Pending scan/pen requests wait with no ack.
//  - Scan read:
//     - Edge k (IDLE): ram_addr<=scan_row, go to SCAN_WAIT.
//     - Edge k+2: scan_data<=ram_rdata, scan_ack=1 for one cycle, go to IDLE. Latency is 2 cycles.
//  - Pen RMW:
//     - Edge k (IDLE): ram_addr<=pen_row; latch pen_col and pen_op.
//     - Edge k+2: ram_wdata <= ram_rdata with bit pen_col (red) and bit COLS+pen_col (green) updated per pen_op; other bits unchanged.
//     - ram_we=1 and pen_ack=1 together for one cycle (PEN_WR), then IDLE.
//  - ram_we is 0 in every state except CLR and PEN_WR.
//  - Back-to-back service: the next grant is taken at the edge where the FSM is in IDLE again.
//  - Simultaneous requests are resolved by priority only; no request is ever dropped.
// CONFIGURATION
//  FRAME_ARB_RR_EN
//   - defined: after any scan grant, a pending pen_req beats scan_req at the next IDLE evaluation (scan/pen alternate); clear still wins.
//   - undefined: fixed priority clear > scan > pen; pen may starve under continuous scan_req.
// TESTING
//  1. clr_req pulse from reset -> ram_we=1 for 8 cycles, addr 0..7, wdata 0, clr_busy=1; then clr_done 1-cycle pulse.
//  2. RAM row 3 = 16'hA55A, scan_req with row 3 -> scan_ack exactly 2 cycles after grant, scan_data=16'hA55A.
//  3. Row 2 = 16'h0000, pen row 2 col 5 op 01 -> ram_we with wdata 16'h0020 plus pen_ack; then op 00 same pixel -> 16'h0000.
//  4. scan_req and pen_req rise together -> default build: scan served first, pen after it.
//     With FRAME_ARB_RR_EN and scan held continuously -> grants alternate scan, pen.
//  5. Pen and scan pending, clr_req asserted -> CLR runs all 8 writes first, then pending requests are served.
//  6. rst_n low at clear cycle 4 -> outputs 0 immediately, no clr_done; a new clr_req restarts from row 0.

Source files
------------

// File: rtl/frame_ram_arbiter.sv
// -----------------------------------------------------------------------------
// frame_ram_arbiter
//
// Sole owner of the single-port 8x8 bicolour frame RAM. Three requesters share
// the port:
//   - clear engine  : writes zero to every row, then pulses clr_done (rst_ok)
//   - scan reader   : reads one row word per refresh slot
//   - light-pen     : read-modify-write of one pixel (red and green bit)
//
// Row word layout: {green[COLS-1:0], red[COLS-1:0]}.
// The RAM is synchronous: ram_rdata is valid one cycle after ram_addr is
// presented. Because ram_addr is itself registered, read data is captured two
// edges after the grant edge.
//
// Ports
//   clk, rst_n              clock, asynchronous active-low reset
//   clr_req                 start full-frame clear (sampled in IDLE)
//   clr_busy / clr_done     clear in progress / 1-cycle completion pulse
//   scan_req/scan_row       scan read request (held until scan_ack) and row
//   scan_ack/scan_data      1-cycle ack with the row word read
//   pen_req/row/col/op      pen write request (held until pen_ack), pixel, op
//                           op: 00 erase, 01 red, 10 green, 11 both
//   pen_ack                 1-cycle ack, coincident with the RMW write
//   ram_addr/we/wdata       registered RAM controls
//   ram_rdata               RAM read data
//
// Build option
//   FRAME_ARB_RR_EN  defined: after a scan grant, a pending pen request beats
//                    a pending scan request at the next IDLE evaluation.
//                    undefined: fixed priority clear > scan > pen.
// -----------------------------------------------------------------------------
module frame_ram_arbiter #(
   parameter int ROWS   = 8,
   parameter int COLS   = 8,
   parameter int ADDR_W = 3
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                clr_req,
   output logic                clr_busy,
   output logic                clr_done,
   input  logic                scan_req,
   input  logic [ADDR_W-1:0]   scan_row,
   output logic                scan_ack,
   output logic [2*COLS-1:0]   scan_data,
   input  logic                pen_req,
   input  logic [ADDR_W-1:0]   pen_row,
   input  logic [ADDR_W-1:0]   pen_col,
   input  logic [1:0]          pen_op,
   output logic                pen_ack,
   output logic [ADDR_W-1:0]   ram_addr,
   output logic                ram_we,
   output logic [2*COLS-1:0]   ram_wdata,
   input  logic [2*COLS-1:0]   ram_rdata
);

   localparam int                W        = 2 * COLS;
   localparam logic [ADDR_W-1:0] LAST_ROW = ADDR_W'(ROWS - 1);
   localparam logic [ADDR_W-1:0] ROW_INC  = ADDR_W'(1);

   typedef enum logic [2:0] {
      ST_IDLE      = 3'd0,
      ST_CLR       = 3'd1,
      ST_SCAN_WAIT = 3'd2,
      ST_SCAN_CAP  = 3'd3,
      ST_PEN_WAIT  = 3'd4,
      ST_PEN_WR    = 3'd5
   } state_t;

   state_t              state_q,     state_d;
   logic [ADDR_W-1:0]   ram_addr_q,  ram_addr_d;
   logic                ram_we_q,    ram_we_d;
   logic [W-1:0]        ram_wdata_q, ram_wdata_d;
   logic [W-1:0]        scan_data_q, scan_data_d;
   logic                scan_ack_q,  scan_ack_d;
   logic                pen_ack_q,   pen_ack_d;
   logic                clr_busy_q,  clr_busy_d;
   logic                clr_done_q,  clr_done_d;
   logic [ADDR_W-1:0]   pen_col_q,   pen_col_d;
   logic [1:0]          pen_op_q,    pen_op_d;
   // PEN_WAIT lasts two cycles (address register + synchronous RAM read)
   logic                phase_q,     phase_d;
`ifdef FRAME_ARB_RR_EN
   // Set after a scan grant: a pending pen request wins the next evaluation
   logic                rr_q,        rr_d;
`endif

   logic clr_ok_s;
   logic scan_ok_s;
   logic pen_ok_s;
   logic pen_first_s;
   logic grant_scan_s;
   logic grant_pen_s;

   // Pixel update: the pixel's red and green bits take the two op bits
   // (op[0] -> red, op[1] -> green); every other bit is kept.
   function automatic logic [W-1:0] pen_apply(input logic [W-1:0]      word,
                                              input logic [ADDR_W-1:0] col,
                                              input logic [1:0]        op);
      logic [W-1:0] res;
      res = word;
      for (int i = 0; i < COLS; i++) begin
         if (i == int'(col)) begin
            res[i]        = op[0];
            res[COLS + i] = op[1];
         end else begin
            res[i]        = word[i];
            res[COLS + i] = word[COLS + i];
         end
      end
      return res;
   endfunction

   // Request qualification and priority; a requester whose ack is high this
   // cycle is ignored so a held request is not served twice.
   always_comb begin
      clr_ok_s  = clr_req  & ~clr_done_q;
      scan_ok_s = scan_req & ~scan_ack_q;
      pen_ok_s  = pen_req  & ~pen_ack_q;
`ifdef FRAME_ARB_RR_EN
      pen_first_s = pen_ok_s & (rr_q | ~scan_ok_s);
`else
      pen_first_s = pen_ok_s & ~scan_ok_s;
`endif
      grant_scan_s = ~clr_ok_s & scan_ok_s & ~pen_first_s;
      grant_pen_s  = ~clr_ok_s & pen_first_s;
   end

   // Next-state and registered-output computation
   always_comb begin
      state_d     = state_q;
      ram_addr_d  = ram_addr_q;
      ram_we_d    = 1'b0;
      ram_wdata_d = ram_wdata_q;
      scan_data_d = scan_data_q;
      scan_ack_d  = 1'b0;
      pen_ack_d   = 1'b0;
      clr_busy_d  = 1'b0;
      clr_done_d  = 1'b0;
      pen_col_d   = pen_col_q;
      pen_op_d    = pen_op_q;
      phase_d     = 1'b0;
`ifdef FRAME_ARB_RR_EN
      rr_d        = rr_q;
`endif
      case (state_q)
         ST_IDLE: begin
            if (clr_ok_s) begin
               state_d     = ST_CLR;
               ram_addr_d  = '0;
               ram_we_d    = 1'b1;
               ram_wdata_d = '0;
               clr_busy_d  = 1'b1;
            end else if (grant_scan_s) begin
               state_d    = ST_SCAN_WAIT;
               ram_addr_d = scan_row;
`ifdef FRAME_ARB_RR_EN
               rr_d       = 1'b1;
`endif
            end else if (grant_pen_s) begin
               state_d    = ST_PEN_WAIT;
               ram_addr_d = pen_row;
               pen_col_d  = pen_col;
               pen_op_d   = pen_op;
`ifdef FRAME_ARB_RR_EN
               rr_d       = 1'b0;
`endif
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_CLR: begin
            if (ram_addr_q == LAST_ROW) begin
               state_d    = ST_IDLE;
               clr_done_d = 1'b1;
            end else begin
               ram_addr_d  = ram_addr_q + ROW_INC;
               ram_we_d    = 1'b1;
               ram_wdata_d = '0;
               clr_busy_d  = 1'b1;
            end
         end
         ST_SCAN_WAIT: begin
            state_d = ST_SCAN_CAP;
         end
         ST_SCAN_CAP: begin
            scan_data_d = ram_rdata;
            scan_ack_d  = 1'b1;
            state_d     = ST_IDLE;
         end
         ST_PEN_WAIT: begin
            if (!phase_q) begin
               phase_d = 1'b1;
            end else begin
               state_d     = ST_PEN_WR;
               ram_we_d    = 1'b1;
               ram_wdata_d = pen_apply(ram_rdata, pen_col_q, pen_op_q);
               pen_ack_d   = 1'b1;
            end
         end
         ST_PEN_WR: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // State and output registers; reset aborts any clear without clr_done
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= ST_IDLE;
         ram_addr_q  <= '0;
         ram_we_q    <= 1'b0;
         ram_wdata_q <= '0;
         scan_data_q <= '0;
         scan_ack_q  <= 1'b0;
         pen_ack_q   <= 1'b0;
         clr_busy_q  <= 1'b0;
         clr_done_q  <= 1'b0;
         pen_col_q   <= '0;
         pen_op_q    <= 2'b00;
         phase_q     <= 1'b0;
      end else begin
         state_q     <= state_d;
         ram_addr_q  <= ram_addr_d;
         ram_we_q    <= ram_we_d;
         ram_wdata_q <= ram_wdata_d;
         scan_data_q <= scan_data_d;
         scan_ack_q  <= scan_ack_d;
         pen_ack_q   <= pen_ack_d;
         clr_busy_q  <= clr_busy_d;
         clr_done_q  <= clr_done_d;
         pen_col_q   <= pen_col_d;
         pen_op_q    <= pen_op_d;
         phase_q     <= phase_d;
      end
   end

`ifdef FRAME_ARB_RR_EN
   // Alternation flag register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rr_q <= 1'b0;
      end else begin
         rr_q <= rr_d;
      end
   end
`endif

   assign ram_addr  = ram_addr_q;
   assign ram_we    = ram_we_q;
   assign ram_wdata = ram_wdata_q;
   assign scan_data = scan_data_q;
   assign scan_ack  = scan_ack_q;
   assign pen_ack   = pen_ack_q;
   assign clr_busy  = clr_busy_q;
   assign clr_done  = clr_done_q;

endmodule

// File: tb/tb_frame_ram_arbiter.sv
// -----------------------------------------------------------------------------
// Testbench for frame_ram_arbiter. A behavioural synchronous RAM (with a
// backdoor load port) sits on the RAM side; ref_mem holds the expected frame
// contents, updated from the pixel rules whenever a pen write is expected.
// -----------------------------------------------------------------------------
module tb_frame_ram_arbiter;

   localparam int ROWS   = 8;
   localparam int COLS   = 8;
   localparam int ADDR_W = 3;
   localparam int W      = 2 * COLS;

   logic              clk = 1'b0;
   logic              rst_n;
   logic              clr_req, clr_busy, clr_done;
   logic              scan_req, scan_ack;
   logic [ADDR_W-1:0] scan_row;
   logic [W-1:0]      scan_data;
   logic              pen_req, pen_ack;
   logic [ADDR_W-1:0] pen_row, pen_col;
   logic [1:0]        pen_op;
   logic [ADDR_W-1:0] ram_addr;
   logic              ram_we;
   logic [W-1:0]      ram_wdata, ram_rdata;

   logic [W-1:0]      mem [ROWS];
   logic              bd_we;
   logic [ADDR_W-1:0] bd_addr;
   logic [W-1:0]      bd_data;

   logic [W-1:0]      ref_mem [ROWS];
   int                pass_cnt = 0;
   int                chk_cnt  = 0;

   frame_ram_arbiter #(.ROWS(ROWS), .COLS(COLS), .ADDR_W(ADDR_W)) dut (
      .clk(clk), .rst_n(rst_n),
      .clr_req(clr_req), .clr_busy(clr_busy), .clr_done(clr_done),
      .scan_req(scan_req), .scan_row(scan_row), .scan_ack(scan_ack), .scan_data(scan_data),
      .pen_req(pen_req), .pen_row(pen_row), .pen_col(pen_col), .pen_op(pen_op), .pen_ack(pen_ack),
      .ram_addr(ram_addr), .ram_we(ram_we), .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
   );

   always #5 clk = ~clk;

   // Synchronous single-port RAM with a backdoor load port
   always @(posedge clk) begin
      if (bd_we) mem[bd_addr] <= bd_data;
      else if (ram_we) mem[ram_addr] <= ram_wdata;
      ram_rdata <= mem[ram_addr];
   end

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   // Expected row word after a pen op: pixel red = op[0], green = op[1]
   function automatic logic [W-1:0] pen_model(input logic [W-1:0] word,
                                              input logic [ADDR_W-1:0] col,
                                              input logic [1:0] op);
      logic [COLS-1:0] red, green;
      red   = word[COLS-1:0];
      green = word[W-1:COLS];
      red[col]   = op[0];
      green[col] = op[1];
      return {green, red};
   endfunction

   task automatic test_reset;
      logic [39:0] outs;
      rst_n = 1'b0;
      clr_req = 1'b0; scan_req = 1'b0; pen_req = 1'b0;
      scan_row = '0; pen_row = '0; pen_col = '0; pen_op = 2'b00;
      bd_we = 1'b0; bd_addr = '0; bd_data = '0;
      repeat (2) tick;
      outs = {clr_busy, clr_done, scan_ack, pen_ack, ram_we, ram_addr, ram_wdata, scan_data};
      chk_cnt++;
      if (outs !== 40'd0) $display("FAIL reset_outputs: got %h expected 0", outs);
      else pass_cnt++;
      rst_n = 1'b1;
      repeat (2) tick;
      outs = {clr_busy, clr_done, scan_ack, pen_ack, ram_we, ram_addr, ram_wdata, scan_data};
      chk_cnt++;
      if (outs !== 40'd0) $display("FAIL idle_after_reset: got %h expected 0", outs);
      else pass_cnt++;
   endtask

   task automatic test_clear(input string tag);
      clr_req = 1'b1;
      tick;
      clr_req = 1'b0;
      for (int i = 0; i < ROWS; i++) begin
         chk_cnt++;
         if (ram_we !== 1'b1 || ram_addr !== ADDR_W'(i) || ram_wdata !== 16'h0000 || clr_busy !== 1'b1)
            $display("FAIL %s_write[%0d]: we=%b addr=%0d wdata=%h busy=%b expected we=1 addr=%0d wdata=0000 busy=1",
                     tag, i, ram_we, ram_addr, ram_wdata, clr_busy, i);
         else pass_cnt++;
         tick;
      end
      chk_cnt++;
      if (clr_done !== 1'b1 || clr_busy !== 1'b0 || ram_we !== 1'b0)
         $display("FAIL %s_done: done=%b busy=%b we=%b expected 1 0 0", tag, clr_done, clr_busy, ram_we);
      else pass_cnt++;
      tick;
      chk_cnt++;
      if (clr_done !== 1'b0) $display("FAIL %s_done_pulse: got %b expected 0", tag, clr_done);
      else pass_cnt++;
      for (int r = 0; r < ROWS; r++) ref_mem[r] = 16'h0000;
   endtask

   task automatic do_scan(input logic [ADDR_W-1:0] row);
      int n;
      bit got;
      scan_row = row;
      scan_req = 1'b1;
      n = 0; got = 1'b0;
      while (!got && n < 20) begin
         tick; n++;
         if (scan_ack === 1'b1) got = 1'b1;
      end
      scan_req = 1'b0;
      chk_cnt++;
      if (!got || n != 3) $display("FAIL scan_latency row %0d: got ack=%b after %0d cycles expected 3", row, got, n);
      else pass_cnt++;
      chk_cnt++;
      if (scan_data !== ref_mem[row]) $display("FAIL scan_data row %0d: got %h expected %h", row, scan_data, ref_mem[row]);
      else pass_cnt++;
      tick;
      chk_cnt++;
      if (scan_ack !== 1'b0) $display("FAIL scan_ack_pulse: got %b expected 0", scan_ack);
      else pass_cnt++;
   endtask

   task automatic do_pen(input logic [ADDR_W-1:0] row, input logic [ADDR_W-1:0] col, input logic [1:0] op);
      int n;
      bit got;
      logic [W-1:0] exp_w;
      exp_w = pen_model(ref_mem[row], col, op);
      pen_row = row; pen_col = col; pen_op = op;
      pen_req = 1'b1;
      n = 0; got = 1'b0;
      while (!got && n < 20) begin
         tick; n++;
         if (pen_ack === 1'b1) got = 1'b1;
      end
      pen_req = 1'b0;
      chk_cnt++;
      if (!got || n != 3) $display("FAIL pen_latency: got ack=%b after %0d cycles expected 3", got, n);
      else pass_cnt++;
      chk_cnt++;
      if (ram_we !== 1'b1 || ram_addr !== row || ram_wdata !== exp_w)
         $display("FAIL pen_write r%0d c%0d op%b: we=%b addr=%0d wdata=%h expected we=1 addr=%0d wdata=%h",
                  row, col, op, ram_we, ram_addr, ram_wdata, row, exp_w);
      else pass_cnt++;
      ref_mem[row] = exp_w;
      tick;
      chk_cnt++;
      if (pen_ack !== 1'b0 || ram_we !== 1'b0) $display("FAIL pen_ack_pulse: ack=%b we=%b expected 0 0", pen_ack, ram_we);
      else pass_cnt++;
   endtask

   task automatic bd_load(input logic [ADDR_W-1:0] row, input logic [W-1:0] data);
      bd_we = 1'b1; bd_addr = row; bd_data = data;
      tick;
      bd_we = 1'b0;
      ref_mem[row] = data;
   endtask

   task automatic test_scan;
      for (int r = 0; r < ROWS; r++) bd_load(ADDR_W'(r), (r == 3) ? 16'hA55A : 16'($urandom));
      do_scan(3'd3);
      chk_cnt++;
      if (scan_data !== 16'hA55A) $display("FAIL scan_row3_const: got %h expected a55a", scan_data);
      else pass_cnt++;
      do_scan(3'd0);
      do_scan(3'd7);
   endtask

   task automatic test_pen;
      bd_load(3'd2, 16'h0000);
      do_pen(3'd2, 3'd5, 2'b01);
      chk_cnt++;
      if (ref_mem[2] !== 16'h0020) $display("FAIL pen_set_red_const: got %h expected 0020", ref_mem[2]);
      else pass_cnt++;
      do_pen(3'd2, 3'd5, 2'b00);
      do_scan(3'd2);
      chk_cnt++;
      if (scan_data !== 16'h0000) $display("FAIL pen_erase_readback: got %h expected 0000", scan_data);
      else pass_cnt++;
   endtask

   task automatic test_random;
      for (int i = 0; i < 40; i++) begin
         if ($urandom_range(0, 1) == 0) do_scan(ADDR_W'($urandom_range(0, ROWS - 1)));
         else do_pen(ADDR_W'($urandom_range(0, ROWS - 1)), ADDR_W'($urandom_range(0, COLS - 1)),
                     2'($urandom_range(0, 3)));
      end
   endtask

   task automatic test_back_to_back;
      int n, scan_t, pen_t;
      logic [W-1:0] exp_w;
      exp_w = pen_model(ref_mem[4], 3'd2, 2'b11);
      scan_row = 3'd1; pen_row = 3'd4; pen_col = 3'd2; pen_op = 2'b11;
      scan_req = 1'b1; pen_req = 1'b1;
      n = 0; scan_t = 0; pen_t = 0;
      while (pen_t == 0 && n < 30) begin
         tick; n++;
         if (scan_ack === 1'b1) begin
            scan_t = n;
`ifndef FRAME_ARB_RR_EN
            scan_req = 1'b0;
`endif
            chk_cnt++;
            if (scan_data !== ref_mem[1]) $display("FAIL b2b_scan_data: got %h expected %h", scan_data, ref_mem[1]);
            else pass_cnt++;
         end
         if (pen_ack === 1'b1) begin
            pen_t = n;
            pen_req = 1'b0;
            scan_req = 1'b0;
            chk_cnt++;
            if (ram_wdata !== exp_w || ram_we !== 1'b1) $display("FAIL b2b_pen_write: got %h we=%b expected %h we=1", ram_wdata, ram_we, exp_w);
            else pass_cnt++;
         end
      end
      scan_req = 1'b0; pen_req = 1'b0;
      ref_mem[4] = exp_w;
      chk_cnt++;
`ifdef FRAME_ARB_RR_EN
      if (!(pen_t == 3 || pen_t == 6)) $display("FAIL b2b_order: got pen ack at %0d expected 3 or 6", pen_t);
      else pass_cnt++;
`else
      if (scan_t != 3 || pen_t != 6) $display("FAIL b2b_order: got scan %0d pen %0d expected scan 3 pen 6", scan_t, pen_t);
      else pass_cnt++;
`endif
      tick;
   endtask

   task automatic test_clear_priority;
      int m, scan_t, pen_t;
      scan_row = 3'd5; pen_row = 3'd6; pen_col = 3'd0; pen_op = 2'b10;
      scan_req = 1'b1; pen_req = 1'b1; clr_req = 1'b1;
      tick;
      clr_req = 1'b0;
      for (int i = 0; i < ROWS; i++) begin
         chk_cnt++;
         if (ram_we !== 1'b1 || ram_addr !== ADDR_W'(i) || clr_busy !== 1'b1 || scan_ack !== 1'b0 || pen_ack !== 1'b0)
            $display("FAIL clrpri_write[%0d]: we=%b addr=%0d busy=%b sack=%b pack=%b expected 1 %0d 1 0 0",
                     i, ram_we, ram_addr, clr_busy, scan_ack, pen_ack, i);
         else pass_cnt++;
         tick;
      end
      chk_cnt++;
      if (clr_done !== 1'b1) $display("FAIL clrpri_done: got %b expected 1", clr_done);
      else pass_cnt++;
      for (int r = 0; r < ROWS; r++) ref_mem[r] = 16'h0000;
      m = 0; scan_t = 0; pen_t = 0;
      while ((scan_t == 0 || pen_t == 0) && m < 30) begin
         tick; m++;
         if (scan_ack === 1'b1) begin
            scan_t = m; scan_req = 1'b0;
            chk_cnt++;
            if (scan_data !== 16'h0000) $display("FAIL clrpri_scan_data: got %h expected 0000", scan_data);
            else pass_cnt++;
         end
         if (pen_ack === 1'b1) begin
            pen_t = m; pen_req = 1'b0;
            chk_cnt++;
            if (ram_wdata !== 16'h0100 || ram_addr !== 3'd6) $display("FAIL clrpri_pen_write: got %h addr %0d expected 0100 addr 6", ram_wdata, ram_addr);
            else pass_cnt++;
         end
      end
      scan_req = 1'b0; pen_req = 1'b0;
      ref_mem[6] = 16'h0100;
      chk_cnt++;
`ifdef FRAME_ARB_RR_EN
      if (!((scan_t == 3 && pen_t == 6) || (pen_t == 3 && scan_t == 6)))
         $display("FAIL clrpri_order: got scan %0d pen %0d expected {3,6}", scan_t, pen_t);
      else pass_cnt++;
`else
      if (scan_t != 3 || pen_t != 6) $display("FAIL clrpri_order: got scan %0d pen %0d expected scan 3 pen 6", scan_t, pen_t);
      else pass_cnt++;
`endif
      tick;
   endtask

   task automatic test_reset_mid_clear;
      logic [39:0] outs;
      clr_req = 1'b1;
      tick;
      clr_req = 1'b0;
      repeat (4) tick;
      chk_cnt++;
      if (ram_addr !== 3'd4 || ram_we !== 1'b1) $display("FAIL midclr_pos: addr=%0d we=%b expected 4 1", ram_addr, ram_we);
      else pass_cnt++;
      rst_n = 1'b0;
      #1;
      outs = {clr_busy, clr_done, scan_ack, pen_ack, ram_we, ram_addr, ram_wdata, scan_data};
      chk_cnt++;
      if (outs !== 40'd0) $display("FAIL midclr_async_reset: got %h expected 0", outs);
      else pass_cnt++;
      for (int i = 0; i < 3; i++) begin
         tick;
         chk_cnt++;
         if (clr_done !== 1'b0 || clr_busy !== 1'b0 || ram_we !== 1'b0) $display("FAIL midclr_hold[%0d]: done=%b busy=%b we=%b expected 0 0 0", i, clr_done, clr_busy, ram_we);
         else pass_cnt++;
      end
      rst_n = 1'b1;
      tick;
      chk_cnt++;
      if (clr_done !== 1'b0 || ram_we !== 1'b0) $display("FAIL midclr_release: done=%b we=%b expected 0 0", clr_done, ram_we);
      else pass_cnt++;
      test_clear("reclear");
      for (int r = 0; r < ROWS; r++) do_scan(ADDR_W'(r));
   endtask

   initial begin
      test_reset;
      test_clear("clear");
      test_scan;
      test_pen;
      test_random;
      test_back_to_back;
      test_clear_priority;
      test_reset_mid_clear;
      $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
      $finish;
   end

endmodule
